// File: rtl/mem_port_scheduler.sv
// Round-robin burst scheduler sharing one memory port between NREQ requesters.
// Optional stall watchdog enabled by defining WATCHDOG_EN.
module mem_port_scheduler #(
    parameter int NREQ    = 4,
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*LEN_W-1:0]   req_len,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    beat_valid,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy,
    output logic                    done,
    output logic                    timeout
);

    localparam int IDW = $clog2(NREQ);

    if (NREQ < 2 || TIMEOUT < 1) begin : g_param_check
        $error("mem_port_scheduler: NREQ must be >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic {IDLE, XFER} state_t;

    state_t            state_q;
    logic [NREQ-1:0]   grant_q;
    logic [IDW-1:0]    grant_id_q;
    logic [NREQ-1:0]   req_ready_q;
    logic              busy_q;
    logic              done_q;
    logic              timeout_q;
    logic [LEN_W-1:0]  beats_q;
    logic [IDW-1:0]    last_id_q;

`ifdef WATCHDOG_EN
    localparam int STW = $clog2(TIMEOUT + 1);
    logic [STW-1:0]    stall_q;
`endif

    logic              any_d;
    logic [IDW-1:0]    win_d;
    logic [LEN_W-1:0]  win_len_d;
    logic [NREQ-1:0]   win_oh_d;

    // Round-robin pick: first valid requester after the last owner, wrapping.
    always_comb begin
        any_d     = 1'b0;
        win_d     = '0;
        win_len_d = '0;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (int'(last_id_q) + k) % NREQ;
            if (!any_d && req_valid[idx]) begin
                any_d     = 1'b1;
                win_d     = idx[IDW-1:0];
                win_len_d = req_len[idx*LEN_W +: LEN_W];
            end
        end
        win_oh_d = {{(NREQ-1){1'b0}}, 1'b1} << win_d;
    end

    // Ownership FSM with all outputs registered.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            grant_id_q  <= '0;
            req_ready_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            beats_q     <= '0;
            last_id_q   <= IDW'(NREQ - 1);
`ifdef WATCHDOG_EN
            stall_q     <= '0;
`endif
        end else begin
            req_ready_q <= '0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_d) begin
                        grant_q     <= win_oh_d;
                        grant_id_q  <= win_d;
                        req_ready_q <= win_oh_d;
                        beats_q     <= win_len_d;
                        last_id_q   <= win_d;
                        busy_q      <= 1'b1;
                        state_q     <= XFER;
`ifdef WATCHDOG_EN
                        stall_q     <= '0;
`endif
                    end
                end
                XFER: begin
                    if (beat_valid) begin
`ifdef WATCHDOG_EN
                        stall_q <= '0;
`endif
                        if (beats_q != '0) begin
                            beats_q <= beats_q - 1'b1;
                        end else begin
                            done_q <= 1'b1;
                            if (any_d) begin
                                grant_q     <= win_oh_d;
                                grant_id_q  <= win_d;
                                req_ready_q <= win_oh_d;
                                beats_q     <= win_len_d;
                                last_id_q   <= win_d;
                            end else begin
                                grant_q    <= '0;
                                grant_id_q <= '0;
                                busy_q     <= 1'b0;
                                state_q    <= IDLE;
                            end
                        end
                    end
`ifdef WATCHDOG_EN
                    // This stalled cycle is the TIMEOUT-th in a row: abort.
                    else if (stall_q == STW'(TIMEOUT - 1)) begin
                        timeout_q  <= 1'b1;
                        grant_q    <= '0;
                        grant_id_q <= '0;
                        busy_q     <= 1'b0;
                        beats_q    <= '0;
                        stall_q    <= '0;
                        state_q    <= IDLE;
                    end else begin
                        stall_q <= stall_q + 1'b1;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant     = grant_q;
    assign grant_id  = grant_id_q;
    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_mem_port_scheduler.sv
// Directed self-checking bench for mem_port_scheduler.
// Scenario tasks run in sequence; watchdog scenario depends on WATCHDOG_EN.
module tb_mem_port_scheduler;

    localparam int NREQ  = 4;
    localparam int LEN_W = 4;

    logic             clk;
    logic             rst_n;
    logic [NREQ-1:0]  req_valid;
    logic [NREQ*LEN_W-1:0] req_len;
    logic [NREQ-1:0]  req_ready;
    logic             beat_valid;
    logic [NREQ-1:0]  grant;
    logic [1:0]       grant_id;
    logic             busy;
    logic             done;
    logic             timeout;

    int n_cmp = 0;
    int n_err = 0;

    mem_port_scheduler #(
        .NREQ(NREQ), .LEN_W(LEN_W), .TIMEOUT(8)
    ) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .req_valid (req_valid),
        .req_len   (req_len),
        .req_ready (req_ready),
        .beat_valid(beat_valid),
        .grant     (grant),
        .grant_id  (grant_id),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        req_valid  = '0;
        req_len    = '0;
        beat_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #2;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        req_valid  = 4'b1111;
        req_len    = '0;
        beat_valid = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({grant, grant_id, busy, done, timeout, req_ready} !== 13'b0) begin
            n_err++;
            $display("FAIL reset: grant=%b id=%0d busy=%b done=%b to=%b rdy=%b want all 0",
                     grant, grant_id, busy, done, timeout, req_ready);
        end
        rst_n = 1'b1;
        req_valid = '0;
        beat_valid = 1'b0;
        #2;
    endtask

    task automatic test_single_burst();
        do_reset();
        req_valid = 4'b0001;
        req_len   = 16'h0003;
        tick();
        n_cmp++;
        if (grant !== 4'b0001 || req_ready !== 4'b0001 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_grant: grant=%b rdy=%b busy=%b want 0001 0001 1",
                     grant, req_ready, busy);
        end
        req_valid  = '0;
        beat_valid = 1'b1;
        tick();
        n_cmp++;
        if (req_ready !== 4'b0000 || done !== 1'b0 || grant !== 4'b0001) begin
            n_err++;
            $display("FAIL single_beat1: rdy=%b done=%b grant=%b want 0000 0 0001",
                     req_ready, done, grant);
        end
        tick();
        tick();
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_beat3: done=%b busy=%b want 0 1", done, busy);
        end
        tick();
        n_cmp++;
        if (done !== 1'b1 || grant !== 4'b0000 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_done: done=%b grant=%b busy=%b want 1 0000 0",
                     done, grant, busy);
        end
        beat_valid = 1'b0;
        tick();
        n_cmp++;
        if (done !== 1'b0 || grant !== 4'b0000) begin
            n_err++;
            $display("FAIL single_after: done=%b grant=%b want 0 0000", done, grant);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_id [5];
        exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        req_valid  = 4'b1111;
        req_len    = '0;
        beat_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (grant_id !== exp_id[i] || busy !== 1'b1 ||
                req_ready !== (4'b0001 << exp_id[i])) begin
                n_err++;
                $display("FAIL b2b[%0d]: id=%0d busy=%b rdy=%b want id=%0d busy=1",
                         i, grant_id, busy, req_ready, exp_id[i]);
            end
            if (i > 0) begin
                n_cmp++;
                if (done !== 1'b1) begin
                    n_err++;
                    $display("FAIL b2b_done[%0d]: done=%b want 1", i, done);
                end
            end
        end
        req_valid = '0;
        tick();
        n_cmp++;
        if (grant !== 4'b0000 || busy !== 1'b0 || done !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_end: grant=%b busy=%b done=%b want 0000 0 1",
                     grant, busy, done);
        end
        beat_valid = 1'b0;
    endtask

    task automatic test_wraparound();
        do_reset();
        req_valid = 4'b0100;
        req_len   = 16'h0200;
        tick();
        n_cmp++;
        if (grant_id !== 2'd2 || grant !== 4'b0100) begin
            n_err++;
            $display("FAIL wrap_own: id=%0d grant=%b want 2 0100", grant_id, grant);
        end
        req_valid  = 4'b1001;
        beat_valid = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (grant_id !== 2'd2 || done !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_hold: id=%0d done=%b want 2 0", grant_id, done);
        end
        tick();
        n_cmp++;
        if (grant_id !== 2'd3 || done !== 1'b1 || req_ready !== 4'b1000) begin
            n_err++;
            $display("FAIL wrap_3: id=%0d done=%b rdy=%b want 3 1 1000",
                     grant_id, done, req_ready);
        end
        tick();
        n_cmp++;
        if (grant_id !== 2'd0 || done !== 1'b1 || req_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL wrap_0: id=%0d done=%b rdy=%b want 0 1 0001",
                     grant_id, done, req_ready);
        end
        req_valid = '0;
        tick();
        n_cmp++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_idle: grant=%b busy=%b want 0000 0", grant, busy);
        end
        beat_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        req_valid = 4'b0100;
        req_len   = 16'h0500;
        tick();
        req_valid  = '0;
        beat_valid = 1'b1;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL arst_clear: grant=%b busy=%b want 0000 0", grant, busy);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL arst_nodone: done=%b want 0", done);
        end
        #2;
        rst_n      = 1'b1;
        beat_valid = 1'b0;
        req_valid  = 4'b0011;
        req_len    = '0;
        tick();
        n_cmp++;
        if (grant_id !== 2'd0 || grant !== 4'b0001 || done !== 1'b0) begin
            n_err++;
            $display("FAIL arst_first: id=%0d grant=%b done=%b want 0 0001 0",
                     grant_id, grant, done);
        end
        req_valid = '0;
    endtask

    task automatic test_watchdog();
        do_reset();
        req_valid = 4'b0010;
        req_len   = 16'h0030;
        tick();
        req_valid = '0;
`ifdef WATCHDOG_EN
        for (int i = 1; i < 8; i++) begin
            tick();
            n_cmp++;
            if (timeout !== 1'b0 || grant !== 4'b0010) begin
                n_err++;
                $display("FAIL wd_wait[%0d]: to=%b grant=%b want 0 0010",
                         i, timeout, grant);
            end
        end
        tick();
        n_cmp++;
        if (timeout !== 1'b1 || grant !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL wd_fire: to=%b grant=%b busy=%b done=%b want 1 0000 0 0",
                     timeout, grant, busy, done);
        end
        tick();
        n_cmp++;
        if (timeout !== 1'b0) begin
            n_err++;
            $display("FAIL wd_pulse: to=%b want 0", timeout);
        end
`else
        for (int i = 1; i <= 20; i++) begin
            tick();
            n_cmp++;
            if (timeout !== 1'b0 || grant !== 4'b0010 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL nowd_hold[%0d]: to=%b grant=%b busy=%b want 0 0010 1",
                         i, timeout, grant, busy);
            end
        end
`endif
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = '0;
        req_len    = '0;
        beat_valid = 1'b0;
        test_reset();
        test_single_burst();
        test_back_to_back();
        test_wraparound();
        test_async_reset();
        test_watchdog();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
